// File: rtl/dcache_responder_if.sv
// dcache_responder_if: MEM-stage request/response and main-memory req/ack bundle for dcache_responder.
interface dcache_responder_if #(parameter int ADDR_BITS = 32);
  logic                 MemRead_2DM;
  logic                 MemWrite_2DM;
  logic [ADDR_BITS-1:0] data_address_2DM;
  logic [31:0]          data_write_2DM;
  logic [1:0]           data_write_size_2DM;
  logic [31:0]          data_read_fDM;
  logic                 miss;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_be;
  logic                 mem_ack;
  logic [31:0]          mem_rdata;
  modport master (
    output MemRead_2DM, MemWrite_2DM, data_address_2DM, data_write_2DM, data_write_size_2DM,
    output mem_ack, mem_rdata,
    input  data_read_fDM, miss, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
  modport slave (
    input  MemRead_2DM, MemWrite_2DM, data_address_2DM, data_write_2DM, data_write_size_2DM,
    input  mem_ack, mem_rdata,
    output data_read_fDM, miss, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-through, no-write-allocate data cache; DCACHE_STATS_EN adds hit/miss/write counters.
module dcache_responder #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_BITS  = 32
) (
  input  logic CLK,
  input  logic RESET,
  dcache_responder_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_writes
`endif
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;
  state_t                state_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES];
  logic [INDEX_BITS-1:0] idx, midx;
  logic [TAG_BITS-1:0]   tag, mtag;
  logic                  rd, wr, idle, hit, mhit;
  logic [2:0]            lane_n;
  logic [3:0]            be_d;
  logic [31:0]           wd_d, mask, merged;
  assign rd   = bus.MemRead_2DM & ~bus.MemWrite_2DM;
  assign wr   = bus.MemWrite_2DM;
  assign idle = state_q == IDLE;
  assign idx  = bus.data_address_2DM[INDEX_BITS+1:2];
  assign tag  = bus.data_address_2DM[ADDR_BITS-1:INDEX_BITS+2];
  assign midx = bus.mem_addr[INDEX_BITS+1:2];
  assign mtag = bus.mem_addr[ADDR_BITS-1:INDEX_BITS+2];
  assign hit  = rd && valid_q[idx] && tag_q[idx] == tag;
  assign mhit = valid_q[midx] && tag_q[midx] == mtag;
  assign bus.miss          = idle ? (wr | (rd & ~hit)) : state_q != WDONE;
  assign bus.data_read_fDM = idle && hit ? data_q[idx] : '0;
  assign lane_n = bus.data_write_size_2DM == 2'd0 ? 3'd4 : {1'b0, bus.data_write_size_2DM};
  // Lane j (j=0 is bits[31:24]) takes the store byte counted from the most significant end of the span.
  always_comb begin
    be_d = '0;
    wd_d = '0;
    for (int j = 0; j < 4; j++) begin
      if (j >= int'(bus.data_address_2DM[1:0]) && j - int'(bus.data_address_2DM[1:0]) < int'(lane_n)) begin
        be_d[3-j]          = 1'b1;
        wd_d[8*(3-j) +: 8] = bus.data_write_2DM[8*(int'(lane_n) - 1 - j + int'(bus.data_address_2DM[1:0])) +: 8];
      end
    end
  end
  assign mask   = {{8{bus.mem_be[3]}}, {8{bus.mem_be[2]}}, {8{bus.mem_be[1]}}, {8{bus.mem_be[0]}}};
  assign merged = (data_q[midx] & ~mask) | (bus.mem_wdata & mask);
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= {bus.data_address_2DM[ADDR_BITS-1:2], 2'b00};
            bus.mem_be    <= be_d;
            bus.mem_wdata <= wd_d;
            state_q       <= WRITE;
          end else if (rd && !hit) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {bus.data_address_2DM[ADDR_BITS-1:2], 2'b00};
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            state_q       <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            valid_q[midx] <= 1'b1;
            tag_q[midx]   <= mtag;
            data_q[midx]  <= bus.mem_rdata;
            bus.mem_req   <= 1'b0;
            state_q       <= IDLE;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            if (mhit) data_q[midx] <= merged;
            bus.mem_req <= 1'b0;
            state_q     <= WDONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef DCACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_writes <= '0;
    end else begin
      stat_hits   <= stat_hits + 32'(idle && hit);
      stat_misses <= stat_misses + 32'(idle && !wr && rd && !hit);
      stat_writes <= stat_writes + 32'(state_q == WRITE && bus.mem_ack);
    end
  end
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: randomized and directed checks of dcache_responder against a word-level cache/memory model.
module tb_dcache_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  dcache_responder_if bus();
`ifdef DCACHE_STATS_EN
  logic [31:0] sh, sm, sw;
`endif
  dcache_responder dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits(sh),
    .stat_misses(sm),
    .stat_writes(sw)
`endif
  );
  int n_chk = 0;
  int n_fail = 0;
  int e_hits, e_misses, e_writes;
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];
  logic [31:0] mem_m   [logic [31:0]];

  function automatic int mi(input logic [31:0] a);
    return int'((a >> 2) & 32'd63);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[mi(a)] && m_tag[mi(a)] == a[31:8];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.MemRead_2DM = 0; bus.MemWrite_2DM = 0; bus.data_address_2DM = 0;
    bus.data_write_2DM = 0; bus.data_write_size_2DM = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    e_hits = 0; e_misses = 0; e_writes = 0;
  endtask

  task automatic idle_cycle();
    bus.MemRead_2DM = 0; bus.MemWrite_2DM = 0; bus.data_address_2DM = $urandom;
    @(negedge clk);
    n_chk++;
    if ({bus.miss, bus.data_read_fDM} !== 33'd0) begin
      n_fail++; $display("FAIL idle got miss=%b data=%h exp miss=0 data=0", bus.miss, bus.data_read_fDM);
    end
    @(posedge clk); #1;
  endtask

  task automatic read_op(input logic [31:0] a, input int lat);
    logic [31:0] w;
    bus.MemRead_2DM = 1; bus.MemWrite_2DM = 0; bus.data_address_2DM = a;
    @(negedge clk);
    if (m_hit(a)) begin
      n_chk++;
      if (bus.miss !== 1'b0 || bus.data_read_fDM !== m_data[mi(a)]) begin
        n_fail++; $display("FAIL rd_hit a=%h got miss=%b data=%h exp miss=0 data=%h", a, bus.miss, bus.data_read_fDM, m_data[mi(a)]);
      end
      e_hits++;
      @(posedge clk); #1;
    end else begin
      n_chk++;
      if (bus.miss !== 1'b1 || bus.data_read_fDM !== 32'd0) begin
        n_fail++; $display("FAIL rd_miss a=%h got miss=%b data=%h exp miss=1 data=0", a, bus.miss, bus.data_read_fDM);
      end
      w = mem_m.exists(a) ? mem_m[a] : $urandom;
      mem_m[a] = w;
      e_misses++;
      @(posedge clk); #1;
      bus.data_address_2DM = $urandom;
      @(negedge clk);
      n_chk++;
      if ({bus.miss, bus.mem_req, bus.mem_we} !== 3'b110 || bus.mem_addr !== a) begin
        n_fail++; $display("FAIL fill_req got miss=%b req=%b we=%b addr=%h exp 1 1 0 %h", bus.miss, bus.mem_req, bus.mem_we, bus.mem_addr, a);
      end
      repeat (lat) begin
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++;
        if ({bus.miss, bus.mem_req} !== 2'b11 || bus.mem_addr !== a) begin
          n_fail++; $display("FAIL fill_wait got miss=%b req=%b addr=%h exp 1 1 %h", bus.miss, bus.mem_req, bus.mem_addr, a);
        end
      end
      @(posedge clk); #1;
      bus.mem_ack = 1; bus.mem_rdata = w; bus.data_address_2DM = a;
      @(negedge clk);
      n_chk++;
      if (bus.miss !== 1'b1) begin
        n_fail++; $display("FAIL fill_ack_miss got %b exp 1", bus.miss);
      end
      @(posedge clk); #1;
      bus.mem_ack = 0; bus.mem_rdata = $urandom;
      m_valid[mi(a)] = 1; m_tag[mi(a)] = a[31:8]; m_data[mi(a)] = w;
      @(negedge clk);
      n_chk++;
      if ({bus.miss, bus.mem_req} !== 2'b00 || bus.data_read_fDM !== w) begin
        n_fail++; $display("FAIL fill_done a=%h got miss=%b req=%b data=%h exp 0 0 %h", a, bus.miss, bus.mem_req, bus.data_read_fDM, w);
      end
      e_hits++;
      @(posedge clk); #1;
    end
    bus.MemRead_2DM = 0;
  endtask

  task automatic write_op(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d, input int lat, input bit both);
    int n, lane;
    logic [3:0]  xbe;
    logic [31:0] xwd, w, msk, bt;
    n = (sz == 0) ? 4 : int'(sz);
    xbe = 0; xwd = 0; msk = 0;
    for (int k = 0; k < n; k++) begin
      lane = int'(a[1:0]) + k;
      if (lane < 4) begin
        bt = (d >> (8 * (n - 1 - k))) & 32'hFF;
        xbe[3-lane] = 1'b1;
        xwd = xwd | (bt << (8 * (3 - lane)));
        msk = msk | (32'hFF << (8 * (3 - lane)));
      end
    end
    w = a & ~32'd3;
    bus.MemWrite_2DM = 1; bus.MemRead_2DM = both; bus.data_address_2DM = a;
    bus.data_write_2DM = d; bus.data_write_size_2DM = sz;
    @(negedge clk);
    n_chk++;
    if (bus.miss !== 1'b1 || bus.data_read_fDM !== 32'd0) begin
      n_fail++; $display("FAIL wr_first a=%h got miss=%b data=%h exp 1 0", a, bus.miss, bus.data_read_fDM);
    end
    @(posedge clk); #1;
    bus.data_address_2DM = $urandom; bus.data_write_2DM = $urandom; bus.data_write_size_2DM = 2'($urandom);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.miss, bus.mem_req, bus.mem_we} !== 3'b111 || bus.mem_addr !== w || bus.mem_be !== xbe || bus.mem_wdata !== xwd) begin
        n_fail++; $display("FAIL wr_req a=%h sz=%0d got miss=%b req=%b we=%b addr=%h be=%b wd=%h exp 1 1 1 %h %b %h",
                           a, sz, bus.miss, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, w, xbe, xwd);
      end
      @(posedge clk); #1;
    end
    bus.mem_ack = 1;
    @(negedge clk);
    n_chk++;
    if (bus.miss !== 1'b1) begin
      n_fail++; $display("FAIL wr_ack_miss got %b exp 1", bus.miss);
    end
    @(posedge clk); #1;
    bus.mem_ack = 0;
    if (!mem_m.exists(w)) mem_m[w] = 0;
    mem_m[w] = (mem_m[w] & ~msk) | (xwd & msk);
    if (m_hit(w)) m_data[mi(w)] = (m_data[mi(w)] & ~msk) | (xwd & msk);
    e_writes++;
    @(negedge clk);
    n_chk++;
    if ({bus.miss, bus.mem_req} !== 2'b00 || bus.data_read_fDM !== 32'd0) begin
      n_fail++; $display("FAIL wdone got miss=%b req=%b data=%h exp 0 0 0", bus.miss, bus.mem_req, bus.data_read_fDM);
    end
    @(posedge clk); #1;
    bus.MemWrite_2DM = 0; bus.MemRead_2DM = 0;
    @(negedge clk);
    n_chk++;
    if ({bus.miss, bus.mem_req} !== 2'b00) begin
      n_fail++; $display("FAIL wr_reissue got miss=%b req=%b exp 0 0", bus.miss, bus.mem_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'd0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 ||
        bus.miss !== 1'b0 || bus.data_read_fDM !== 32'd0) begin
      n_fail++; $display("FAIL reset_state got req=%b we=%b be=%b addr=%h wd=%h miss=%b data=%h exp all 0",
                         bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.miss, bus.data_read_fDM);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_fill();
    mem_m[32'h100] = 32'hDEADBEEF;
    read_op(32'h100, 2);
    read_op(32'h100, 0);
  endtask

  task automatic test_write_merge();
    write_op(32'h100, 2'd0, 32'h11223344, 1, 0);
    write_op(32'h101, 2'd1, 32'h000000AA, 0, 0);
    bus.MemRead_2DM = 1; bus.data_address_2DM = 32'h100;
    @(negedge clk);
    n_chk++;
    if (bus.miss !== 1'b0 || bus.data_read_fDM !== 32'h11AA3344) begin
      n_fail++; $display("FAIL merge_read got miss=%b data=%h exp 0 11aa3344", bus.miss, bus.data_read_fDM);
    end
    e_hits++;
    @(posedge clk); #1;
    bus.MemRead_2DM = 0;
  endtask

  task automatic test_write_no_allocate();
    write_op(32'h202, 2'd3, 32'h00A1B2C3, 2, 0);
    read_op(32'h200, 1);
  endtask

  task automatic test_conflict();
    read_op(32'h000, 0);
    read_op(32'h100, 1);
    read_op(32'h000, 0);
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    mem_m[32'h100] = 32'h0BADF00D;
    bus.MemRead_2DM = 1; bus.data_address_2DM = 32'h300;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; bus.MemRead_2DM = 0;
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    @(negedge clk);
    n_chk++;
    if ({bus.mem_req, bus.miss} !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset got req=%b miss=%b exp 0 0", bus.mem_req, bus.miss);
    end
    @(posedge clk); #1;
    bus.mem_ack = 1; bus.mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus.mem_ack = 0;
    @(negedge clk);
    n_chk++;
    if ({bus.mem_req, bus.miss} !== 2'b00) begin
      n_fail++; $display("FAIL late_ack got req=%b miss=%b exp 0 0", bus.mem_req, bus.miss);
    end
    @(posedge clk); #1;
    read_op(32'h100, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int t = 0; t < 60; t++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 2);
      case ($urandom_range(0, 3))
        0:       idle_cycle();
        3:       write_op(a | 32'($urandom_range(0, 3)), 2'($urandom), $urandom, $urandom_range(0, 3), 1'($urandom));
        default: read_op(a, $urandom_range(0, 3));
      endcase
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    do_reset();
    read_op(32'h400, 1);
    read_op(32'h404, 0);
    read_op(32'h400, 0);
    write_op(32'h500, 2'd2, 32'h0000BEEF, 1, 0);
    @(negedge clk);
    n_chk++;
    if (sh !== 32'(e_hits) || sm !== 32'(e_misses) || sw !== 32'(e_writes) || e_hits != 3 || e_misses != 2 || e_writes != 1) begin
      n_fail++; $display("FAIL stats got h=%0d m=%0d w=%0d exp 3 2 1", sh, sm, sw);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_read_fill();
    test_write_merge();
    test_write_no_allocate();
    test_conflict();
    test_reset_mid_fill();
    test_random();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
